sensor_packet_buffer: RTL and testbench

Coherent double-buffered packet store between the BNO085 controller's sample outputs and the MCU SPI slave. It captures quaternion and gyro samples into a shadow register set as they arrive. On each MCU frame start it commits a consistent 16-byte packet, carrying freshness/staleness flags and a sequence number, to a read bank. The SPI slave then fetches that packet byte by byte with single-cycle registered latency.

---
 rtl/sensor_packet_buffer_if.sv | 36 +++
 rtl/sensor_packet_buffer.sv | 114 +++++++++++
 tb/tb_sensor_packet_buffer.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sensor_packet_buffer_if.sv
// Bus bundle between the BNO085 sample producer, the MCU SPI slave and the
// packet buffer. The buffer takes the slave side; producers/readers take master.
interface sensor_packet_buffer_if;
  // Valid pulses carry no ready: a sample or frame_start is taken on the edge
  // where its valid/strobe is high, with no backpressure toward the producer.
  logic        quat_valid;
  logic [15:0] quat_w;
  logic [15:0] quat_x;
  logic [15:0] quat_y;
  logic [15:0] quat_z;
  logic        gyro_valid;
  logic [15:0] gyro_x;
  logic [15:0] gyro_y;
  logic [15:0] gyro_z;
  logic        frame_start;
  logic [3:0]  byte_idx;
  logic [7:0]  byte_data;
  logic        snapshot_valid;
  logic        quat_stale;
  logic        gyro_stale;
  logic        state_dbg;

  modport master (
    output quat_valid, quat_w, quat_x, quat_y, quat_z,
    output gyro_valid, gyro_x, gyro_y, gyro_z,
    output frame_start, byte_idx,
    input  byte_data, snapshot_valid, quat_stale, gyro_stale, state_dbg
  );

  modport slave (
    input  quat_valid, quat_w, quat_x, quat_y, quat_z,
    input  gyro_valid, gyro_x, gyro_y, gyro_z,
    input  frame_start, byte_idx,
    output byte_data, snapshot_valid, quat_stale, gyro_stale, state_dbg
  );
endinterface

// File: rtl/sensor_packet_buffer.sv
// Double-buffered sensor packet store: shadow bank collects samples, frame_start
// commits a coherent 16-byte packet to the read bank served to the SPI slave.
module sensor_packet_buffer #(
    parameter int          STALE_CYCLES = 300000,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sensor_packet_buffer_if.slave bus
);

    localparam int AW = (STALE_CYCLES < 1) ? 1 : $clog2(STALE_CYCLES + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(STALE_CYCLES);

    typedef enum logic {EMPTY = 1'b0, LOADED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [15:0]     sh_w, sh_x, sh_y, sh_z, sh_gx, sh_gy, sh_gz;
    logic [AW-1:0]   q_age, g_age;
    logic            q_fresh, g_fresh;
    logic [3:0]      seq;
    logic [127:0]    rd_bank, commit_pkt, bank_next;
    logic [7:0]      flags, byte_next, byte_q;
    logic            q_stale, g_stale;

    assign q_stale = (q_age == AGE_MAX);
    assign g_stale = (g_age == AGE_MAX);

    assign bus.quat_stale     = q_stale;
    assign bus.gyro_stale     = g_stale;
    assign bus.byte_data      = byte_q;
    assign bus.snapshot_valid = (state_q == LOADED);
    assign bus.state_dbg      = state_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (bus.frame_start) state_d = LOADED;
            LOADED:  state_d = LOADED;
            default: state_d = EMPTY;
        endcase
    end

    // Commit uses pre-edge shadow and flag values, so a sample landing on the
    // frame_start edge belongs to the next packet.
    assign flags      = {q_fresh, g_fresh, q_stale, g_stale, seq};
    assign commit_pkt = {HEADER, flags, sh_w, sh_x, sh_y, sh_z, sh_gx, sh_gy, sh_gz};
    assign bank_next  = bus.frame_start ? commit_pkt : rd_bank;

    always_comb begin
        byte_next = 8'h00;
        if (state_d == LOADED) begin
            for (int i = 0; i < 16; i++) begin
                if (bus.byte_idx == 4'(i)) byte_next = bank_next[127 - 8*i -: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_w    <= '0;
            sh_x    <= '0;
            sh_y    <= '0;
            sh_z    <= '0;
            sh_gx   <= '0;
            sh_gy   <= '0;
            sh_gz   <= '0;
            q_age   <= AGE_MAX;
            g_age   <= AGE_MAX;
            q_fresh <= 1'b0;
            g_fresh <= 1'b0;
            seq     <= 4'd0;
            rd_bank <= '0;
            byte_q  <= 8'h00;
        end else begin
            if (bus.quat_valid) begin
                sh_w  <= bus.quat_w;
                sh_x  <= bus.quat_x;
                sh_y  <= bus.quat_y;
                sh_z  <= bus.quat_z;
                q_age <= '0;
            end else if (q_age != AGE_MAX) begin
                q_age <= q_age + AW'(1);
            end

            if (bus.gyro_valid) begin
                sh_gx <= bus.gyro_x;
                sh_gy <= bus.gyro_y;
                sh_gz <= bus.gyro_z;
                g_age <= '0;
            end else if (g_age != AGE_MAX) begin
                g_age <= g_age + AW'(1);
            end

            if (bus.quat_valid)       q_fresh <= 1'b1;
            else if (bus.frame_start) q_fresh <= 1'b0;
            if (bus.gyro_valid)       g_fresh <= 1'b1;
            else if (bus.frame_start) g_fresh <= 1'b0;

            if (bus.frame_start) begin
                rd_bank <= commit_pkt;
                seq     <= seq + 4'd1;
            end

            byte_q <= byte_next;
        end
    end

endmodule

// File: tb/tb_sensor_packet_buffer.sv
// Bench for sensor_packet_buffer: directed scenarios plus randomized traffic
// checked against a byte-level packet model.
module tb_sensor_packet_buffer;
  localparam int         STALE = 10;
  localparam logic [7:0] HDR   = 8'hAA;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  sensor_packet_buffer_if bus ();
  sensor_packet_buffer_if bus1 ();

  sensor_packet_buffer #(.STALE_CYCLES(STALE), .HEADER(HDR)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  sensor_packet_buffer #(.STALE_CYCLES(1), .HEADER(HDR)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave)
  );

  assign bus1.quat_valid  = bus.quat_valid;
  assign bus1.quat_w      = bus.quat_w;
  assign bus1.quat_x      = bus.quat_x;
  assign bus1.quat_y      = bus.quat_y;
  assign bus1.quat_z      = bus.quat_z;
  assign bus1.gyro_valid  = bus.gyro_valid;
  assign bus1.gyro_x      = bus.gyro_x;
  assign bus1.gyro_y      = bus.gyro_y;
  assign bus1.gyro_z      = bus.gyro_z;
  assign bus1.frame_start = bus.frame_start;
  assign bus1.byte_idx    = bus.byte_idx;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: sample words, fresh flags, cycles since last sample, packet bytes
  logic [15:0] m_q[4];
  logic [15:0] m_g[3];
  logic        m_qfresh, m_gfresh, m_loaded;
  int          m_qage, m_gage, m_seq;
  logic [7:0]  m_pkt[16];
  logic [7:0]  m_byte;

  task automatic model_edge();
    logic [15:0] words[7];
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_q[i] = 16'h0;
      for (int i = 0; i < 3; i++) m_g[i] = 16'h0;
      for (int i = 0; i < 16; i++) m_pkt[i] = 8'h00;
      m_qfresh = 0; m_gfresh = 0; m_loaded = 0;
      m_qage = STALE; m_gage = STALE; m_seq = 0; m_byte = 8'h00;
    end else begin
      if (bus.frame_start) begin
        for (int k = 0; k < 4; k++) words[k] = m_q[k];
        for (int k = 0; k < 3; k++) words[4+k] = m_g[k];
        m_pkt[0] = HDR;
        m_pkt[1] = {m_qfresh, m_gfresh, (m_qage >= STALE), (m_gage >= STALE), 4'(m_seq)};
        for (int k = 0; k < 7; k++) begin
          m_pkt[2+2*k] = words[k][15:8];
          m_pkt[3+2*k] = words[k][7:0];
        end
        m_seq = (m_seq + 1) % 16;
        m_qfresh = 0; m_gfresh = 0; m_loaded = 1;
      end
      if (bus.quat_valid) begin
        m_q[0] = bus.quat_w; m_q[1] = bus.quat_x; m_q[2] = bus.quat_y; m_q[3] = bus.quat_z;
        m_qfresh = 1; m_qage = 0;
      end else if (m_qage < STALE) m_qage++;
      if (bus.gyro_valid) begin
        m_g[0] = bus.gyro_x; m_g[1] = bus.gyro_y; m_g[2] = bus.gyro_z;
        m_gfresh = 1; m_gage = 0;
      end else if (m_gage < STALE) m_gage++;
      m_byte = m_loaded ? m_pkt[bus.byte_idx] : 8'h00;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    bus.quat_valid = 0; bus.gyro_valid = 0; bus.frame_start = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
  endtask

  task automatic drive_quat(input logic [15:0] w, x, y, z);
    bus.quat_valid = 1; bus.quat_w = w; bus.quat_x = x; bus.quat_y = y; bus.quat_z = z;
  endtask

  task automatic drive_gyro(input logic [15:0] x, y, z);
    bus.gyro_valid = 1; bus.gyro_x = x; bus.gyro_y = y; bus.gyro_z = z;
  endtask

  // scenarios
  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    checks++;
    if (bus.byte_data !== 8'h00) begin errors++; $display("FAIL reset_byte got %h want 00", bus.byte_data); end
    checks++;
    if (bus.snapshot_valid !== 1'b0) begin errors++; $display("FAIL reset_snap got %b want 0", bus.snapshot_valid); end
    checks++;
    if (bus.quat_stale !== 1'b1 || bus.gyro_stale !== 1'b1) begin
      errors++; $display("FAIL reset_stale got q=%b g=%b want 1 1", bus.quat_stale, bus.gyro_stale);
    end
    checks++;
    if (bus.state_dbg !== 1'b0) begin errors++; $display("FAIL reset_state got %b want 0", bus.state_dbg); end
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      bus.byte_idx = 4'(i);
      tick();
      checks++;
      if (bus.byte_data !== 8'h00) begin errors++; $display("FAIL empty_byte%0d got %h want 00", i, bus.byte_data); end
    end
  endtask

  task automatic test_basic_packet();
    logic [7:0] exp[16];
    exp = '{8'hAA, 8'hC0, 8'h12, 8'h34, 8'hFF, 8'hFE, 8'h00, 8'h00,
            8'h80, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_reset();
    drive_quat(16'h1234, 16'hFFFE, 16'h0000, 16'h8000);
    drive_gyro(16'h0102, 16'h0304, 16'h0506);
    tick();
    idle_inputs();
    bus.frame_start = 1;
    tick();
    bus.frame_start = 0;
    for (int i = 0; i < 16; i++) begin
      bus.byte_idx = 4'(i);
      tick();
      checks++;
      if (bus.byte_data !== exp[i] || bus.byte_data !== m_byte) begin
        errors++; $display("FAIL basic_byte%0d got %h want %h", i, bus.byte_data, exp[i]);
      end
    end
    checks++;
    if (bus.snapshot_valid !== 1'b1) begin errors++; $display("FAIL basic_snap got %b want 1", bus.snapshot_valid); end
  endtask

  task automatic test_coherence();
    do_reset();
    bus.frame_start = 1;
    tick();
    bus.frame_start = 0;
    for (int i = 2; i < 10; i++) begin
      bus.byte_idx = 4'(i);
      if (i == 4) drive_quat(16'h5555, 16'h1111, 16'h2222, 16'h3333);
      tick();
      idle_inputs();
      checks++;
      if (bus.byte_data !== 8'h00 || bus.byte_data !== m_byte) begin
        errors++; $display("FAIL coherent_byte%0d got %h want 00", i, bus.byte_data);
      end
    end
    bus.frame_start = 1;
    bus.byte_idx = 4'd1;
    tick();
    bus.frame_start = 0;
    checks++;
    if ((bus.byte_data & 8'hCF) !== 8'h81 || bus.byte_data !== m_byte) begin
      errors++; $display("FAIL coherent_flags got %h want %h", bus.byte_data, m_byte);
    end
    for (int i = 2; i < 4; i++) begin
      bus.byte_idx = 4'(i);
      tick();
      checks++;
      if (bus.byte_data !== 8'h55) begin errors++; $display("FAIL coherent_w%0d got %h want 55", i, bus.byte_data); end
    end
  endtask

  task automatic test_simultaneous();
    drive_quat(16'hAAAA, 16'h0, 16'h0, 16'h0);
    bus.frame_start = 1;
    bus.byte_idx = 4'd2;
    tick();
    idle_inputs();
    checks++;
    if (bus.byte_data !== 8'h55) begin errors++; $display("FAIL simul_old_w got %h want 55", bus.byte_data); end
    bus.byte_idx = 4'd1;
    tick();
    checks++;
    if (bus.byte_data[7] !== 1'b0 || bus.byte_data !== m_byte) begin
      errors++; $display("FAIL simul_flags got %h want %h", bus.byte_data, m_byte);
    end
    bus.frame_start = 1;
    tick();
    bus.frame_start = 0;
    checks++;
    if (bus.byte_data[7] !== 1'b1 || bus.byte_data !== m_byte) begin
      errors++; $display("FAIL simul_next_flags got %h want %h", bus.byte_data, m_byte);
    end
    bus.byte_idx = 4'd3;
    tick();
    checks++;
    if (bus.byte_data !== 8'hAA) begin errors++; $display("FAIL simul_next_w got %h want AA", bus.byte_data); end
  endtask

  task automatic test_stale();
    drive_quat(16'h0F0F, 16'h1, 16'h2, 16'h3);
    tick();
    idle_inputs();
    for (int i = 0; i < STALE - 1; i++) tick();
    checks++;
    if (bus.quat_stale !== 1'b0) begin errors++; $display("FAIL stale_early got %b want 0", bus.quat_stale); end
    tick();
    checks++;
    if (bus.quat_stale !== 1'b1) begin errors++; $display("FAIL stale_at_limit got %b want 1", bus.quat_stale); end
    bus.frame_start = 1;
    bus.byte_idx = 4'd1;
    tick();
    bus.frame_start = 0;
    checks++;
    if (bus.byte_data[5] !== 1'b1 || bus.byte_data !== m_byte) begin
      errors++; $display("FAIL stale_flag got %h want %h", bus.byte_data, m_byte);
    end
  endtask

  task automatic test_seq_wrap();
    int s0;
    s0 = m_seq;
    bus.byte_idx = 4'd1;
    for (int k = 0; k <= 16; k++) begin
      bus.frame_start = 1;
      tick();
      checks++;
      if (bus.byte_data[3:0] !== 4'((s0 + k) % 16)) begin
        errors++; $display("FAIL seq_frame%0d got %h want %h", k, bus.byte_data[3:0], 4'((s0 + k) % 16));
      end
    end
    bus.frame_start = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0)
        drive_quat(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 7) == 0)
        drive_gyro(16'($urandom), 16'($urandom), 16'($urandom));
      bus.frame_start = ($urandom_range(0, 19) == 0);
      bus.byte_idx = 4'($urandom_range(0, 15));
      tick();
      checks++;
      if (bus.byte_data !== m_byte || bus.snapshot_valid !== m_loaded ||
          bus.quat_stale !== (m_qage >= STALE) || bus.gyro_stale !== (m_gage >= STALE)) begin
        errors++;
        $display("FAIL random_cycle%0d got byte=%h snap=%b qs=%b gs=%b want byte=%h snap=%b qs=%b gs=%b",
                 c, bus.byte_data, bus.snapshot_valid, bus.quat_stale, bus.gyro_stale,
                 m_byte, m_loaded, (m_qage >= STALE), (m_gage >= STALE));
      end
    end
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_min_stale();
    do_reset();
    bus.frame_start = 1;
    tick();
    bus.frame_start = 0;
    for (int i = 0; i < 16; i++) begin
      bus.byte_idx = 4'(i);
      tick();
      checks++;
      if ($isunknown(bus1.byte_data)) begin errors++; $display("FAIL min_stale_x byte%0d got %h want known", i, bus1.byte_data); end
    end
    bus.byte_idx = 4'd0;
    tick();
    checks++;
    if (bus1.byte_data !== HDR) begin errors++; $display("FAIL min_stale_hdr got %h want %h", bus1.byte_data, HDR); end
  endtask

  initial begin
    rst_n = 0;
    bus.quat_w = 0; bus.quat_x = 0; bus.quat_y = 0; bus.quat_z = 0;
    bus.gyro_x = 0; bus.gyro_y = 0; bus.gyro_z = 0;
    bus.byte_idx = 0;
    idle_inputs();
    test_reset();
    test_basic_packet();
    test_coherence();
    test_simultaneous();
    test_stale();
    test_seq_wrap();
    test_random();
    test_min_stale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
